fullchip_seq: RTL and testbench

- Instruction sequencer that sits directly upstream of fullchip and drives its 17-bit inst bus and mem_in data bus.
- Accepts Q and K vectors from a host over a valid/ready stream.
- Then autonomously issues the full sequence: qmem write, kmem write, K load, execute, drain wait, ofifo-to-pmem move.
- Replaces hand-sequenced instruction driving with a reusable hardware controller.

---
 rtl/fullchip_seq_pkg.sv | 28 ++
 rtl/fullchip_seq_cnt.sv | 34 +++
 rtl/fullchip_seq.sv | 198 +++++++++++++++++++
 tb/tb_fullchip_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fullchip_seq_pkg.sv
// Shared state encoding and instruction-word layout for the fullchip instruction sequencer.
package fullchip_seq_pkg;

    typedef enum logic [3:0] {
        IDLE, QWR, KWR, LOAD, GAP, EXEC, DRAIN, MOVE, RDBK, DONE
    } state_e;

    localparam int INST_W        = 17;
    localparam int INST_OFIFO_RD = 16;
    localparam int INST_EXECUTE  = 7;
    localparam int INST_LOAD     = 6;
    localparam int INST_QMEM_RD  = 5;
    localparam int INST_QMEM_WR  = 4;
    localparam int INST_KMEM_RD  = 3;
    localparam int INST_KMEM_WR  = 2;
    localparam int INST_PMEM_RD  = 1;
    localparam int INST_PMEM_WR  = 0;

    localparam int QK_ADD_LSB   = 12;
    localparam int PMEM_ADD_LSB = 8;

    localparam logic [INST_W-1:0] QK_ADD_MASK = 17'h0F000;

    function automatic logic [INST_W-1:0] addr_field(input int unsigned lsb, input logic [3:0] addr);
        return INST_W'(addr) << lsb;
    endfunction

endpackage

// File: rtl/fullchip_seq_cnt.sv
// 5-bit loadable up-counter with terminal-count flag; a single instance times every sequencer phase.
module fullchip_seq_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       en_i,
    input  logic [4:0] load_val_i,
    input  logic [4:0] term_i,
    output logic [4:0] cnt_o,
    output logic       tc_o
);
    logic [4:0] cnt_q, cnt_d;

    // NOTE: default first so every path assigns cnt_d; a missing else branch would infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (en_i)
            cnt_d = cnt_q + 5'd1;
    end

    // NOTE: non-blocking so every register updates from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= 5'd0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/fullchip_seq.sv
// Instruction sequencer driving fullchip's inst/mem_in buses from a host Q/K vector stream.
// Build option: define FULLCHIP_SEQ_READBACK_EN to add the pmem readback phase (RDBK) and rd_valid.
module fullchip_seq
    import fullchip_seq_pkg::*;
#(
    parameter int bw        = 8,
    parameter int pr        = 16,
    parameter int col       = 8,
    parameter int load_gap  = 10,
    parameter int drain_cyc = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [3:0]          num_q,
    input  logic [pr*bw-1:0]    din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [INST_W-1:0]   inst,
    output logic [pr*bw-1:0]    mem_in,
    output logic                busy,
    output logic                done,
    output logic                rd_valid
);
    state_e              state_q, state_d;
    logic [3:0]          num_q_q, num_q_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [pr*bw-1:0]    mem_in_q, mem_in_d;
    logic                din_ready_q, busy_q, done_q, done_d;
    logic                cnt_load, cnt_en, cnt_tc, beat;
    logic [4:0]          cnt, cnt_term;

    assign beat = din_valid && din_ready_q;

    fullchip_seq_cnt u_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .load_val_i (5'd0),
        .term_i     (cnt_term),
        .cnt_o      (cnt),
        .tc_o       (cnt_tc)
    );

    // Next state: every phase ends when the shared counter reaches its terminal index.
    always_comb begin
        state_d  = state_q;
        num_q_d  = num_q_q;
        cnt_term = 5'd0;
        cnt_en   = 1'b0;
        cnt_load = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = QWR;
                num_q_d = num_q;
            end
            QWR: begin
                cnt_term = {1'b0, num_q_q};
                cnt_en   = beat;
                if (beat && cnt_tc) state_d = KWR;
            end
            KWR: begin
                cnt_term = 5'(col - 1);
                cnt_en   = beat;
                if (beat && cnt_tc) state_d = LOAD;
            end
            LOAD: begin
                cnt_term = 5'(col + 1);
                cnt_en   = 1'b1;
                if (cnt_tc) state_d = GAP;
            end
            GAP: begin
                cnt_term = 5'(load_gap - 1);
                cnt_en   = 1'b1;
                if (cnt_tc) state_d = EXEC;
            end
            EXEC: begin
                cnt_term = {1'b0, num_q_q};
                cnt_en   = 1'b1;
                if (cnt_tc) state_d = DRAIN;
            end
            DRAIN: begin
                cnt_term = 5'(drain_cyc - 1);
                cnt_en   = 1'b1;
                if (cnt_tc) state_d = MOVE;
            end
            MOVE: begin
                cnt_term = {1'b0, num_q_q};
                cnt_en   = 1'b1;
`ifdef FULLCHIP_SEQ_READBACK_EN
                if (cnt_tc) state_d = RDBK;
`else
                if (cnt_tc) state_d = DONE;
`endif
            end
`ifdef FULLCHIP_SEQ_READBACK_EN
            RDBK: begin
                cnt_term = {1'b0, num_q_q};
                cnt_en   = 1'b1;
                if (cnt_tc) state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_load = 1'b1;
    end

    // Output words for the current phase cycle; they appear on inst one edge later.
    always_comb begin
        inst_d   = '0;
        mem_in_d = mem_in_q;
        done_d   = 1'b0;
        case (state_q)
            QWR, KWR: begin
                if (beat) begin
                    mem_in_d = din;
                    inst_d   = addr_field(QK_ADD_LSB, cnt[3:0]);
                    if (state_q == QWR)
                        inst_d[INST_QMEM_WR] = 1'b1;
                    else
                        inst_d[INST_KMEM_WR] = 1'b1;
                end else begin
                    inst_d = inst_q & QK_ADD_MASK;
                end
            end
            LOAD: begin
                inst_d[INST_LOAD] = 1'b1;
                if (cnt != 5'd0 && cnt <= 5'(col)) begin
                    inst_d               = inst_d | addr_field(QK_ADD_LSB, 4'(cnt - 5'd1));
                    inst_d[INST_KMEM_RD] = 1'b1;
                end
            end
            EXEC: begin
                inst_d               = addr_field(QK_ADD_LSB, cnt[3:0]);
                inst_d[INST_EXECUTE] = 1'b1;
                inst_d[INST_QMEM_RD] = 1'b1;
            end
            MOVE: begin
                inst_d                = addr_field(PMEM_ADD_LSB, cnt[3:0]);
                inst_d[INST_OFIFO_RD] = 1'b1;
                inst_d[INST_PMEM_WR]  = 1'b1;
            end
`ifdef FULLCHIP_SEQ_READBACK_EN
            RDBK: begin
                inst_d               = addr_field(PMEM_ADD_LSB, cnt[3:0]);
                inst_d[INST_PMEM_RD] = 1'b1;
            end
`endif
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            num_q_q     <= 4'd0;
            inst_q      <= '0;
            mem_in_q    <= '0;
            din_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q_q     <= num_q_d;
            inst_q      <= inst_d;
            mem_in_q    <= mem_in_d;
            din_ready_q <= (state_d == QWR) || (state_d == KWR);
            busy_q      <= (state_d != IDLE);
            done_q      <= done_d;
        end
    end

`ifdef FULLCHIP_SEQ_READBACK_EN
    logic rd_valid_q;

    // pmem data returns one cycle after its read address, so rd_valid trails pmem_rd.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rd_valid_q <= 1'b0;
        else
            rd_valid_q <= inst_q[INST_PMEM_RD];
    end

    assign rd_valid = rd_valid_q;
`else
    assign rd_valid = 1'b0;
`endif

    assign din_ready = din_ready_q;
    assign inst      = inst_q;
    assign mem_in    = mem_in_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fullchip_seq.sv
// Self-checking bench for fullchip_seq: cycle-level reference model built from the phase rules.
module tb_fullchip_seq;

    localparam int BW        = 8;
    localparam int PR        = 16;
    localparam int COL       = 8;
    localparam int LOAD_GAP  = 10;
    localparam int DRAIN_CYC = 10;
    localparam int DW        = PR * BW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    num_q;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [16:0]   inst;
    logic [DW-1:0] mem_in;
    logic          busy;
    logic          done;
    logic          rd_valid;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] exp_mem;
    logic [16:0]   prev_inst;
    logic [16:0]   exp_q[$];
    logic [16:0]   trace[0:255];
    int            done_seen;

    always #5 clk = ~clk;

    fullchip_seq #(
        .bw(BW), .pr(PR), .col(COL), .load_gap(LOAD_GAP), .drain_cyc(DRAIN_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_q     (num_q),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .inst      (inst),
        .mem_in    (mem_in),
        .busy      (busy),
        .done      (done),
        .rd_valid  (rd_valid)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] rand_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // rd_valid is expected exactly one cycle after any word carrying pmem_rd (bit 1).
    task automatic check_outputs(input string ph, input logic [16:0] e_inst,
                                 input bit e_busy, input bit e_done, input bit e_ready);
        check({ph, ".inst"},      DW'(inst),      DW'(e_inst));
        check({ph, ".busy"},      DW'(busy),      DW'(e_busy));
        check({ph, ".done"},      DW'(done),      DW'(e_done));
        check({ph, ".din_ready"}, DW'(din_ready), DW'(e_ready));
        check({ph, ".mem_in"},    mem_in,         exp_mem);
        check({ph, ".rd_valid"},  DW'(rd_valid),  DW'(prev_inst[1]));
        prev_inst = e_inst;
    endtask

    task automatic after_edge(inout int edges);
        @(posedge clk);
        #1;
        start = 1'b0;
        num_q = 4'($urandom());
        edges++;
        if (edges < 256) trace[edges] = inst;
        if (done === 1'b1 && done_seen < 0) done_seen = edges;
    endtask

    task automatic run_seq(input int nq, input int stall_pct, input bit directed_stall,
                           input bit poke_start, input int abort_idx);
        int            edges;
        int            rdbk;
        logic [DW-1:0] d;
        logic [16:0]   e;
        edges     = 0;
        done_seen = -1;

        num_q     = 4'(nq);
        start     = 1'b1;
        din_valid = 1'($urandom_range(0, 1));
        din       = rand_vec();
        after_edge(edges);
        edges = 0;
        trace[0] = inst;
        check_outputs("start", 17'd0, 1'b1, 1'b0, 1'b1);

        // Q then K write phases: each accepted beat lands at the next free address.
        for (int ph = 0; ph < 2; ph++) begin
            int n;
            int beat;
            int stalls;
            int guard;
            n      = (ph == 0) ? nq + 1 : COL;
            beat   = 0;
            stalls = 0;
            guard  = 0;
            while (beat < n) begin
                bit v;
                v = ($urandom_range(0, 99) >= stall_pct) || (guard > 100);
                if (directed_stall && ph == 0 && beat == 3 && stalls < 3) begin
                    v = 1'b0;
                    stalls++;
                end
                d         = rand_vec();
                din       = d;
                din_valid = v;
                if (poke_start && ph == 1 && beat == 2) start = 1'b1;
                after_edge(edges);
                guard++;
                if (v) begin
                    exp_mem = d;
                    e = 17'(beat << 12) | ((ph == 0) ? 17'h00010 : 17'h00004);
                    beat++;
                end else begin
                    e = prev_inst & 17'h0F000;
                end
                check_outputs((ph == 0) ? "qwr" : "kwr", e, 1'b1, 1'b0, (ph == 0) || (beat < n));
            end
        end

        exp_q.delete();
        for (int c = 0; c < COL + 2; c++)
            exp_q.push_back((c >= 1 && c <= COL) ? 17'(((c - 1) << 12) | 'h48) : 17'h00040);
        repeat (LOAD_GAP) exp_q.push_back(17'd0);
        for (int i = 0; i <= nq; i++) exp_q.push_back(17'((i << 12) | 'hA0));
        repeat (DRAIN_CYC) exp_q.push_back(17'd0);
        for (int i = 0; i <= nq; i++) exp_q.push_back(17'('h10000 | (i << 8) | 'h01));
        rdbk = 0;
`ifdef FULLCHIP_SEQ_READBACK_EN
        for (int i = 0; i <= nq; i++) exp_q.push_back(17'((i << 8) | 'h02));
        rdbk = nq + 1;
`endif
        exp_q.push_back(17'd0);

        for (int k = 0; k < exp_q.size(); k++) begin
            bit last;
            last      = (k == exp_q.size() - 1);
            din       = rand_vec();
            din_valid = 1'($urandom_range(0, 1));
            if (poke_start && k == COL + 2 + LOAD_GAP + nq + 1 + 2) start = 1'b1;
            after_edge(edges);
            check_outputs("seq", exp_q[k], !last, last, 1'b0);
            if (k == abort_idx) begin
                reset = 1'b0;
                #1;
                exp_mem   = '0;
                prev_inst = '0;
                check_outputs("rst_mid", 17'd0, 1'b0, 1'b0, 1'b0);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
        end

        if (stall_pct == 0 && !directed_stall)
            check("done_edge", DW'(done_seen),
                  DW'((nq + 1) + COL + (COL + 2) + LOAD_GAP + (nq + 1) + DRAIN_CYC + (nq + 1) + rdbk + 1));
    endtask

    initial begin
        int edges;
        edges     = 0;
        reset     = 1'b0;
        start     = 1'b0;
        num_q     = 4'd0;
        din       = '0;
        din_valid = 1'b0;
        exp_mem   = '0;
        prev_inst = '0;
        done_seen = -1;

        #2;
        check_outputs("reset", 17'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Host data offered while idle must be ignored.
        din       = rand_vec();
        din_valid = 1'b1;
        after_edge(edges);
        check_outputs("idle", 17'd0, 1'b0, 1'b0, 1'b0);

        run_seq(7, 0, 1'b0, 1'b0, -1);
        check("qwr_beat3", DW'(trace[4]),  DW'(17'h03010));
        check("load_cyc3", DW'(trace[20]), DW'(17'h02048));
        check("exec_beat3", DW'(trace[40]), DW'(17'h030A0));
        check("move_beat5", DW'(trace[60]), DW'(17'h10501));

        run_seq(7, 0, 1'b0, 1'b0, COL + 2 + LOAD_GAP + 3);
        run_seq(5, 0, 1'b0, 1'b0, -1);
        run_seq(4, 0, 1'b1, 1'b0, -1);
        run_seq(6, 30, 1'b0, 1'b1, -1);
        run_seq(15, 0, 1'b0, 1'b0, -1);
        for (int i = 0; i < 4; i++)
            run_seq(int'($urandom_range(0, 15)), 25, 1'b0, 1'($urandom_range(0, 1)), -1);
        run_seq(3, 0, 1'b0, 1'b1, -1);

        din_valid = 1'b0;
        after_edge(edges);
        check_outputs("final_idle", 17'd0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
